reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Receiving end of the rename/dispatch interface: one instance per functional-unit class (ALU, MUL, CMP, LD/ST).
- Accepts `rs_t` entries when its dispatch strobe is high and holds them.
- Snoops the four CDB ports to clear operand busy bits and capture values.
- Issues the oldest fully-ready entry to its functional unit under a valid/ready handshake; reports `rs_full` back to rename.

Parameters:
- DEPTH, 4, number of entries; any power of two, 2 to 16.
- TAG_W, 4, ROB tag width; must match `cdb_t.tag` and `rs_t.rob_entry`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- flush  in  1  synchronous squash of all entries (mispredict recovery).
- dispatch  in  1  rename strobe for this station; write `rs_in` this edge.
- rs_in  in  $bits(rs_t)  dispatched entry (operands, busy_1/2, rs1_rob/rs2_rob, rob_entry, ops, imm, pc).
- rs_full  out  1  no free entry; rename must not dispatch.
- cdb1..cdb4  in  $bits(cdb_t) each  broadcast {valid, tag, value}.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  functional unit accepts this cycle.
- issue_entry  out  $bits(rs_t)  selected entry, operands resolved.

Behaviour:
- Reset (rst=0, async):
  - all entry valid bits = 0; age counters = 0.
  - rs_full = 0, issue_valid = 0, issue_entry = '0.
- Per-entry state: valid, age[$clog2(DEPTH)-1:0], rs_t payload.
- Allocation:
  - On dispatch=1 with rs_full=0, write rs_in into the lowest-index free slot; set valid=1, age=0.
  - Age of every other valid entry increments, saturating at DEPTH-1.
  - Dispatch while rs_full=1 is ignored: no write, no state change. Benches flag this as a protocol error.
- rs_full:
  - = (valid count == DEPTH), from registered state only.
  - Not relieved combinationally by a same-cycle issue.
  - Prevents a rename→RS→rename combinational loop.
- Wakeup, every cycle, for each valid entry with busy_k=1:
  - Compare rsk_rob against each cdbN with cdbN.valid=1.
  - On a match: busy_k <= 0, rk_v <= cdbN.value.
  - If several ports match, priority is cdb1 > cdb2 > cdb3 > cdb4.
- CDB traffic in the dispatch cycle:
  - Rename already snooped the CDB combinationally, so rs_in arrives pre-woken.
  - The station does not re-snoop rs_in on its write cycle.
  - Wakeup for a new entry starts the cycle after the write.
- Ready: valid && !busy_1 && !busy_2.
  - An entry woken at edge T is issuable from cycle T+1 (registered value, no CDB bypass to issue).
- Select:
  - Among ready entries, pick the largest age.
  - Ties go to the lowest index.
  - issue_valid = any ready entry; issue_entry = selected payload, combinational from state; '0 when issue_valid=0.
- Handshake:
  - On issue_valid && issue_ready, the selected entry's valid <= 0 at the edge.
  - issue_entry may change while issue_ready=0 if an older entry becomes ready. There is no hold requirement; the FU samples only on the accept cycle.
- Simultaneous dispatch and issue in one cycle:
  - Both take effect.
  - The freed slot is not reusable by that same dispatch; allocation uses the pre-edge free set.
  - Count is unchanged.
- flush=1:
  - All valid bits <= 0 at the edge.
  - Overrides a same-cycle dispatch and issue; the FU must also discard its accept.
- Reset mid-operation: async clear regardless of a pending handshake. issue_valid drops immediately.

Decomposition:
- `rs_t` and `cdb_t` stay in `rv32i_types`.
- Add to `rv32i_types`: constant `RS_DEPTH` = 4 and `ROB_TAG_W` = 4.
- Sub-module `rs_select`:
  - inputs: ready vector, age array.
  - outputs: one-hot grant and valid.
  - Purely combinational oldest-first picker.
- Entry array, wakeup and allocation live in `reservation_station`.

Test Plan:
- Fill/full:
  - Action: 4 dispatches of entries with busy_1=busy_2=1, issue_ready=0.
  - Expect: rs_full=1 the cycle after the 4th write. A 5th dispatch leaves the contents unchanged.
- Wakeup:
  - Action: entry {rs1_rob=3, busy_1=1, rs2_rob=5, busy_2=1}; cdb2 {valid, tag 3, 0xDEAD_BEEF}; next cycle cdb4 {valid, tag 5, 0x0000_0011}.
  - Expect: issue_valid=1 one cycle after the second broadcast, r1_v=0xDEADBEEF, r2_v=0x11.
- CDB priority:
  - Action: cdb1 and cdb3 both tag 7, values 0x1 and 0x2, against busy_1 tag 7.
  - Expect: r1_v=0x1.
- Oldest-first:
  - Action: dispatch A (busy), then B (ready), C (ready); wake A.
  - Expect: issue order B, C, then A once A is ready. With A ready first, A issues before B and C.
- Backpressure:
  - Action: ready entry with issue_ready=0 for 3 cycles, then 1.
  - Expect: entry retained; freed exactly on the accept edge; rs_full drops the following cycle if it was full.
- Flush/reset:
  - Action: 3 valid entries, flush with a same-cycle dispatch.
  - Expect: zero entries next cycle, issue_valid=0.
  - Action: rst low mid-cycle.
  - Expect: issue_valid=0 and rs_full=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rename/dispatch types: station entry and CDB broadcast formats.
// Pure type/constant package; no logic.
// Widths are tied to ROB_TAG_W so tags compare directly across blocks.
package rv32i_types;

    localparam int RS_DEPTH  = 4;
    localparam int ROB_TAG_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [31:0]          value;
    } cdb_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic [3:0]           op;
        logic [ROB_TAG_W-1:0] rob_entry;
        logic [ROB_TAG_W-1:0] rs1_rob;
        logic                 busy_1;
        logic [31:0]          r1_v;
        logic [ROB_TAG_W-1:0] rs2_rob;
        logic                 busy_2;
        logic [31:0]          r2_v;
    } rs_t;

endpackage

// File: rtl/reservation_station_if.sv
// Rename/CDB/functional-unit bundle seen by one reservation station.
// Combinational wiring only; master drives dispatch, CDB and issue_ready.
// rs_full back-pressures rename, issue_ready back-pressures issue.
interface reservation_station_if;
    import rv32i_types::*;

    logic flush;
    logic dispatch;
    rs_t  rs_in;
    logic rs_full;
    cdb_t cdb1;
    cdb_t cdb2;
    cdb_t cdb3;
    cdb_t cdb4;
    logic issue_valid;
    logic issue_ready;
    rs_t  issue_entry;

    modport master (
        output flush, dispatch, rs_in, cdb1, cdb2, cdb3, cdb4, issue_ready,
        input  rs_full, issue_valid, issue_entry
    );

    modport slave (
        input  flush, dispatch, rs_in, cdb1, cdb2, cdb3, cdb4, issue_ready,
        output rs_full, issue_valid, issue_entry
    );

endinterface

// File: rtl/rs_select.sv
// Oldest-first picker: grants the ready entry with the largest age.
// Purely combinational, zero latency; ties resolve to the lowest index.
// No backpressure of its own; the caller qualifies the grant with issue_ready.
module rs_select #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic [DEPTH-1:0]         ready,
    input  logic [DEPTH-1:0][AW-1:0] age,
    output logic [DEPTH-1:0]         grant,
    output logic                     valid
);

    logic [AW-1:0] best_age;

    // Strict '>' keeps the earliest index on equal ages.
    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!valid || age[i] > best_age)) begin
                grant    = '0;
                grant[i] = 1'b1;
                valid    = 1'b1;
                best_age = age[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Holds dispatched entries, wakes operands from four CDB ports, issues oldest ready.
// Dispatch-to-issue 1 cycle for pre-woken entries; wakeup-to-issue 1 cycle.
// rs_full (registered state only) stalls rename; issue holds while issue_ready=0.
module reservation_station
    import rv32i_types::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave rs_if
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] age_q;
    rs_t                      ent_q [DEPTH];
    rs_t                      woken [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic             any_ready;
    logic             do_alloc;
    logic             accept;
    logic [AW-1:0]    free_idx;
    rs_t              sel_entry;
    cdb_t             cdb [4];

    assign cdb[0] = rs_if.cdb1;
    assign cdb[1] = rs_if.cdb2;
    assign cdb[2] = rs_if.cdb3;
    assign cdb[3] = rs_if.cdb4;

    function automatic logic tag_hit(input cdb_t c, input logic [TAG_W-1:0] t);
        return c.valid && (TAG_W'(c.tag) == t);
    endfunction

    // Walk ports from cdb4 up to cdb1 so the lowest-numbered match lands last.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            for (int n = 3; n >= 0; n--) begin
                if (ent_q[i].busy_1 && tag_hit(cdb[n], ent_q[i].rs1_rob)) begin
                    woken[i].busy_1 = 1'b0;
                    woken[i].r1_v   = cdb[n].value;
                end
                if (ent_q[i].busy_2 && tag_hit(cdb[n], ent_q[i].rs2_rob)) begin
                    woken[i].busy_2 = 1'b0;
                    woken[i].r2_v   = cdb[n].value;
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = AW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && !ent_q[i].busy_1 && !ent_q[i].busy_2;
        end
    end

    rs_select #(.DEPTH(DEPTH), .AW(AW)) u_select (
        .ready (ready),
        .age   (age_q),
        .grant (grant),
        .valid (any_ready)
    );

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) sel_entry = ent_q[i];
        end
    end

    assign rs_if.rs_full     = &valid_q;
    assign rs_if.issue_valid = any_ready;
    assign rs_if.issue_entry = sel_entry;

    assign do_alloc = rs_if.dispatch && !rs_if.rs_full;
    assign accept   = any_ready && rs_if.issue_ready;

    // The write slot comes from the pre-edge free set, so a slot freed by a
    // same-cycle issue is never the target; the incoming entry is not re-snooped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            age_q   <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else if (rs_if.flush) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_alloc && free_idx == AW'(i)) begin
                    valid_q[i] <= 1'b1;
                    age_q[i]   <= '0;
                    ent_q[i]   <= rs_if.rs_in;
                end else begin
                    ent_q[i] <= woken[i];
                    if (accept && grant[i]) valid_q[i] <= 1'b0;
                    if (do_alloc && valid_q[i] && age_q[i] != AGE_MAX)
                        age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios plus randomized traffic against a stamp-based reference model.
module tb_reservation_station;
    import rv32i_types::*;

    localparam int D = RS_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reservation_station_if rs_if();

    reservation_station #(.DEPTH(D), .TAG_W(ROB_TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (rs_if)
    );

    int passed = 0;
    int total  = 0;

    // Model: each entry remembers the global dispatch count at its write;
    // age = dispatches since then, capped at D-1.
    logic m_valid [D];
    int   m_stamp [D];
    rs_t  m_ent   [D];
    int   dcount;

    function automatic int m_pick();
        int best = -1;
        int bage = -1;
        for (int i = 0; i < D; i++) begin
            if (m_valid[i] && !m_ent[i].busy_1 && !m_ent[i].busy_2) begin
                int a = dcount - m_stamp[i];
                if (a > D - 1) a = D - 1;
                if (a > bage) begin
                    best = i;
                    bage = a;
                end
            end
        end
        return best;
    endfunction

    function automatic logic m_full();
        int n = 0;
        for (int i = 0; i < D; i++) if (m_valid[i]) n++;
        return n == D;
    endfunction

    function automatic logic m_iv();
        return m_pick() >= 0;
    endfunction

    function automatic rs_t m_ie();
        rs_t r = '0;
        int  p = m_pick();
        if (p >= 0) r = m_ent[p];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        dcount = 0;
    endtask

    task automatic model_step();
        int   pick;
        int   fr;
        cdb_t c [4];
        pick = m_pick();
        fr   = -1;
        c[0] = rs_if.cdb1; c[1] = rs_if.cdb2; c[2] = rs_if.cdb3; c[3] = rs_if.cdb4;
        for (int i = 0; i < D; i++) if (!m_valid[i] && fr < 0) fr = i;
        if (rs_if.flush) begin
            for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (m_valid[i]) begin
                    for (int n = 0; n < 4; n++) begin
                        if (m_ent[i].busy_1 && c[n].valid && c[n].tag == m_ent[i].rs1_rob) begin
                            m_ent[i].busy_1 = 1'b0;
                            m_ent[i].r1_v   = c[n].value;
                        end
                        if (m_ent[i].busy_2 && c[n].valid && c[n].tag == m_ent[i].rs2_rob) begin
                            m_ent[i].busy_2 = 1'b0;
                            m_ent[i].r2_v   = c[n].value;
                        end
                    end
                end
            end
            if (rs_if.issue_ready && pick >= 0) m_valid[pick] = 1'b0;
            if (rs_if.dispatch && fr >= 0) begin
                dcount++;
                m_valid[fr] = 1'b1;
                m_stamp[fr] = dcount;
                m_ent[fr]   = rs_if.rs_in;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rs_if.flush       = 1'b0;
        rs_if.dispatch    = 1'b0;
        rs_if.rs_in       = '0;
        rs_if.cdb1        = '0;
        rs_if.cdb2        = '0;
        rs_if.cdb3        = '0;
        rs_if.cdb4        = '0;
        rs_if.issue_ready = 1'b0;
    endtask

    function automatic rs_t mk(logic [31:0] pc, logic b1, logic [3:0] t1, logic b2, logic [3:0] t2);
        rs_t e = '0;
        e.pc        = pc;
        e.imm       = $urandom;
        e.op        = 4'($urandom_range(0, 15));
        e.rob_entry = 4'($urandom_range(0, 15));
        e.busy_1    = b1;
        e.rs1_rob   = t1;
        e.r1_v      = b1 ? 32'h0 : $urandom;
        e.busy_2    = b2;
        e.rs2_rob   = t2;
        e.r2_v      = b2 ? 32'h0 : $urandom;
        return e;
    endfunction

    function automatic cdb_t mkc(logic [3:0] tag, logic [31:0] val);
        cdb_t c;
        c.valid = 1'b1;
        c.tag   = tag;
        c.value = val;
        return c;
    endfunction

    task automatic dispatch_one(rs_t e);
        rs_if.dispatch = 1'b1;
        rs_if.rs_in    = e;
        tick();
        rs_if.dispatch = 1'b0;
    endtask

    task automatic flush_all();
        idle();
        rs_if.flush = 1'b1;
        tick();
        rs_if.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst = 1'b0;
        #2;
        total++; if (rs_if.rs_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", rs_if.rs_full); else passed++;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b expected 0", rs_if.issue_valid); else passed++;
        total++; if (rs_if.issue_entry !== rs_t'(0)) $display("FAIL reset_issue_entry: got %h expected 0", rs_if.issue_entry); else passed++;
        #6 rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_full();
        flush_all();
        for (int k = 0; k < 4; k++) begin
            dispatch_one(mk(32'h100 + k, 1'b1, 4'(k), 1'b1, 4'(k + 8)));
            total++;
            if (rs_if.rs_full !== (k == 3)) $display("FAIL fill_full_%0d: got %b expected %b", k, rs_if.rs_full, (k == 3));
            else passed++;
        end
        dispatch_one(mk(32'h1FF, 1'b0, 4'd0, 1'b0, 4'd0));
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL overflow_ignored: got issue_valid %b expected 0", rs_if.issue_valid); else passed++;
        total++; if (rs_if.rs_full !== 1'b1) $display("FAIL overflow_full: got %b expected 1", rs_if.rs_full); else passed++;
        for (int k = 0; k < 4; k++) begin
            rs_if.cdb1 = mkc(4'(k), 32'hA000_0000 + k);
            rs_if.cdb2 = mkc(4'(k + 8), 32'hB000_0000 + k);
            tick();
        end
        idle();
        rs_if.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rs_if.issue_valid !== 1'b1 || rs_if.issue_entry.pc !== 32'h100 + k ||
                rs_if.issue_entry.r1_v !== 32'hA000_0000 + k || rs_if.issue_entry.r2_v !== 32'hB000_0000 + k)
                $display("FAIL drain_%0d: got v=%b pc=%h r1=%h r2=%h expected pc=%h r1=%h r2=%h", k,
                         rs_if.issue_valid, rs_if.issue_entry.pc, rs_if.issue_entry.r1_v, rs_if.issue_entry.r2_v,
                         32'h100 + k, 32'hA000_0000 + k, 32'hB000_0000 + k);
            else passed++;
            total++; if (rs_if.issue_entry !== m_ie()) $display("FAIL drain_entry_%0d: got %h expected %h", k, rs_if.issue_entry, m_ie()); else passed++;
            tick();
        end
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.issue_valid !== 1'b0 || rs_if.rs_full !== 1'b0)
            $display("FAIL drained_empty: got v=%b full=%b expected 0 0", rs_if.issue_valid, rs_if.rs_full); else passed++;
    endtask

    task automatic test_wakeup();
        flush_all();
        dispatch_one(mk(32'h200, 1'b1, 4'd3, 1'b1, 4'd5));
        rs_if.cdb2 = mkc(4'd3, 32'hDEAD_BEEF);
        tick();
        rs_if.cdb2 = '0;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL wake_half: got %b expected 0", rs_if.issue_valid); else passed++;
        rs_if.cdb4 = mkc(4'd5, 32'h0000_0011);
        tick();
        rs_if.cdb4 = '0;
        total++; if (rs_if.issue_valid !== 1'b1) $display("FAIL wake_valid: got %b expected 1", rs_if.issue_valid); else passed++;
        total++; if (rs_if.issue_entry.r1_v !== 32'hDEAD_BEEF) $display("FAIL wake_r1: got %h expected deadbeef", rs_if.issue_entry.r1_v); else passed++;
        total++; if (rs_if.issue_entry.r2_v !== 32'h11) $display("FAIL wake_r2: got %h expected 11", rs_if.issue_entry.r2_v); else passed++;
        rs_if.issue_ready = 1'b1;
        tick();
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL wake_issued: got %b expected 0", rs_if.issue_valid); else passed++;
    endtask

    task automatic test_cdb_priority();
        flush_all();
        rs_if.cdb1 = mkc(4'd7, 32'h55);
        dispatch_one(mk(32'h300, 1'b1, 4'd7, 1'b0, 4'd0));
        rs_if.cdb1 = '0;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL no_resnoop: got %b expected 0", rs_if.issue_valid); else passed++;
        rs_if.cdb1 = mkc(4'd7, 32'h1);
        rs_if.cdb3 = mkc(4'd7, 32'h2);
        tick();
        idle();
        total++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_entry.r1_v !== 32'h1)
            $display("FAIL cdb_priority: got v=%b r1=%h expected 1 00000001", rs_if.issue_valid, rs_if.issue_entry.r1_v); else passed++;
    endtask

    task automatic test_oldest_first();
        flush_all();
        dispatch_one(mk(32'h400, 1'b1, 4'd2, 1'b0, 4'd0));
        dispatch_one(mk(32'h401, 1'b0, 4'd0, 1'b0, 4'd0));
        dispatch_one(mk(32'h402, 1'b0, 4'd0, 1'b0, 4'd0));
        rs_if.issue_ready = 1'b1;
        total++; if (rs_if.issue_entry.pc !== 32'h401) $display("FAIL order_b: got %h expected 401", rs_if.issue_entry.pc); else passed++;
        tick();
        total++; if (rs_if.issue_entry.pc !== 32'h402) $display("FAIL order_c: got %h expected 402", rs_if.issue_entry.pc); else passed++;
        tick();
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL order_a_busy: got %b expected 0", rs_if.issue_valid); else passed++;
        rs_if.cdb1 = mkc(4'd2, 32'h77);
        tick();
        idle();
        total++; if (rs_if.issue_entry.pc !== 32'h400 || rs_if.issue_entry.r1_v !== 32'h77)
            $display("FAIL order_a: got pc=%h r1=%h expected 400 77", rs_if.issue_entry.pc, rs_if.issue_entry.r1_v); else passed++;

        flush_all();
        dispatch_one(mk(32'h410, 1'b1, 4'd2, 1'b0, 4'd0));
        dispatch_one(mk(32'h411, 1'b0, 4'd0, 1'b0, 4'd0));
        dispatch_one(mk(32'h412, 1'b0, 4'd0, 1'b0, 4'd0));
        total++; if (rs_if.issue_entry.pc !== 32'h411) $display("FAIL order2_pre: got %h expected 411", rs_if.issue_entry.pc); else passed++;
        rs_if.cdb1 = mkc(4'd2, 32'h88);
        tick();
        idle();
        rs_if.issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (rs_if.issue_entry.pc !== 32'h410 + k) $display("FAIL order2_%0d: got %h expected %h", k, rs_if.issue_entry.pc, 32'h410 + k); else passed++;
            tick();
        end
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.issue_valid !== 1'b0) $display("FAIL order2_empty: got %b expected 0", rs_if.issue_valid); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h502; exp_pc[1] = 32'h503; exp_pc[2] = 32'h5F0; exp_pc[3] = 32'h5F1;
        flush_all();
        for (int k = 0; k < 4; k++) dispatch_one(mk(32'h500 + k, 1'b0, 4'd0, 1'b0, 4'd0));
        for (int c = 0; c < 3; c++) begin
            total++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_entry.pc !== 32'h500 || rs_if.rs_full !== 1'b1)
                $display("FAIL hold_%0d: got v=%b pc=%h full=%b expected 1 500 1", c, rs_if.issue_valid, rs_if.issue_entry.pc, rs_if.rs_full); else passed++;
            tick();
        end
        rs_if.issue_ready = 1'b1;
        tick();
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.rs_full !== 1'b0 || rs_if.issue_entry.pc !== 32'h501)
            $display("FAIL accept_edge: got full=%b pc=%h expected 0 501", rs_if.rs_full, rs_if.issue_entry.pc); else passed++;
        rs_if.issue_ready = 1'b1;
        dispatch_one(mk(32'h5F0, 1'b0, 4'd0, 1'b0, 4'd0));
        rs_if.issue_ready = 1'b0;
        total++; if (rs_if.rs_full !== 1'b0) $display("FAIL simul_count: got full=%b expected 0", rs_if.rs_full); else passed++;
        dispatch_one(mk(32'h5F1, 1'b0, 4'd0, 1'b0, 4'd0));
        total++; if (rs_if.rs_full !== 1'b1) $display("FAIL simul_refill: got full=%b expected 1", rs_if.rs_full); else passed++;
        rs_if.issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (rs_if.issue_entry.pc !== exp_pc[k]) $display("FAIL simul_order_%0d: got %h expected %h", k, rs_if.issue_entry.pc, exp_pc[k]); else passed++;
            tick();
        end
        rs_if.issue_ready = 1'b0;
    endtask

    task automatic test_flush();
        flush_all();
        for (int k = 0; k < 3; k++) dispatch_one(mk(32'h600 + k, 1'b0, 4'd0, 1'b0, 4'd0));
        rs_if.flush       = 1'b1;
        rs_if.dispatch    = 1'b1;
        rs_if.rs_in       = mk(32'h6FF, 1'b0, 4'd0, 1'b0, 4'd0);
        rs_if.issue_ready = 1'b1;
        tick();
        idle();
        total++; if (rs_if.issue_valid !== 1'b0 || rs_if.rs_full !== 1'b0)
            $display("FAIL flush_clear: got v=%b full=%b expected 0 0", rs_if.issue_valid, rs_if.rs_full); else passed++;
        for (int k = 0; k < 3; k++) dispatch_one(mk(32'h610 + k, 1'b1, 4'd12, 1'b0, 4'd0));
        total++; if (rs_if.rs_full !== 1'b0) $display("FAIL flush_count: got full=%b expected 0", rs_if.rs_full); else passed++;
    endtask

    task automatic test_async_reset();
        flush_all();
        for (int k = 0; k < 4; k++) dispatch_one(mk(32'h700 + k, 1'b0, 4'd0, 1'b0, 4'd0));
        total++; if (rs_if.issue_valid !== 1'b1 || rs_if.rs_full !== 1'b1)
            $display("FAIL pre_reset: got v=%b full=%b expected 1 1", rs_if.issue_valid, rs_if.rs_full); else passed++;
        rs_if.issue_ready = 1'b1;
        #3 rst = 1'b0;
        #1;
        total++; if (rs_if.issue_valid !== 1'b0 || rs_if.rs_full !== 1'b0 || rs_if.issue_entry !== rs_t'(0))
            $display("FAIL async_reset: got v=%b full=%b entry=%h expected 0 0 0", rs_if.issue_valid, rs_if.rs_full, rs_if.issue_entry); else passed++;
        idle();
        model_reset();
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        flush_all();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs_if.flush       = ($urandom_range(0, 49) == 0);
            rs_if.dispatch    = m_full() ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            rs_if.rs_in       = mk($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            rs_if.cdb1        = $urandom_range(0, 1) ? mkc(4'($urandom_range(0, 7)), $urandom) : '0;
            rs_if.cdb2        = $urandom_range(0, 1) ? mkc(4'($urandom_range(0, 7)), $urandom) : '0;
            rs_if.cdb3        = $urandom_range(0, 1) ? mkc(4'($urandom_range(0, 7)), $urandom) : '0;
            rs_if.cdb4        = $urandom_range(0, 1) ? mkc(4'($urandom_range(0, 7)), $urandom) : '0;
            rs_if.issue_ready = 1'($urandom_range(0, 1));
            total++; if (rs_if.rs_full !== m_full()) $display("FAIL rand_full@%0d: got %b expected %b", cyc, rs_if.rs_full, m_full()); else passed++;
            total++; if (rs_if.issue_valid !== m_iv()) $display("FAIL rand_valid@%0d: got %b expected %b", cyc, rs_if.issue_valid, m_iv()); else passed++;
            total++; if (rs_if.issue_entry !== m_ie()) $display("FAIL rand_entry@%0d: got %h expected %h", cyc, rs_if.issue_entry, m_ie()); else passed++;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_wakeup();
        test_cdb_priority();
        test_oldest_first();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
